// File: rtl/hazard_unit.sv
// hazard_unit
// Control-side companion to the ID/EX pipeline register of the 16-bit,
// 8-register pipelined MIPS. It watches the register fields and control
// bits published by the decode, ID/EX, EX/MEM and MEM/WB stages, and drives
// the stall, flush and forwarding controls back into the pipeline.
//
// Ports
//   clk, reset                  clock and asynchronous active-high reset
//   i_IfId_Rs / i_IfId_Rt       source fields of the instruction in ID
//   i_IdEx_Rs / i_IdEx_Rt       source fields of the instruction in EX
//   i_IdEx_MemRead              instruction in EX is a load
//   i_ExMem_Rd / _RegWrite      destination and write enable in MEM
//   i_MemWb_Rd / _RegWrite      destination and write enable in WB
//   i_Branch_Taken              branch resolved taken in MEM
//   o_Pc_Write, o_IfId_Write    PC and IF/ID load enables
//   o_Flush_IfId/IdEx/ExMem     zero the respective pipeline register
//   o_Fwd_A, o_Fwd_B            EX operand selects (00 RF, 10 EX/MEM, 01 MEM/WB)
//   o_Stall_Count, o_Flush_Count saturating event counters
//
// Control outputs are combinational from the inputs and the current state so
// they settle before the falling edge, where the pipeline registers sample.

module hazard_unit #(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] i_IfId_Rs,
  input  logic [REG_W-1:0] i_IfId_Rt,
  input  logic [REG_W-1:0] i_IdEx_Rs,
  input  logic [REG_W-1:0] i_IdEx_Rt,
  input  logic             i_IdEx_MemRead,
  input  logic [REG_W-1:0] i_ExMem_Rd,
  input  logic             i_ExMem_RegWrite,
  input  logic [REG_W-1:0] i_MemWb_Rd,
  input  logic             i_MemWb_RegWrite,
  input  logic             i_Branch_Taken,
  output logic             o_Pc_Write,
  output logic             o_IfId_Write,
  output logic             o_Flush_IfId,
  output logic             o_Flush_IdEx,
  output logic             o_Flush_ExMem,
  output logic [1:0]       o_Fwd_A,
  output logic [1:0]       o_Fwd_B,
  output logic [CNT_W-1:0] o_Stall_Count,
  output logic [CNT_W-1:0] o_Flush_Count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
  logic [CNT_W-1:0] flushCnt_q, flushCnt_d;

  logic       loadUse;
  logic       takeStall, takeFlush;
  logic       pcWrite, ifIdWrite;
  logic       flushIfId, flushIdEx, flushExMem;
  logic [1:0] fwdA, fwdB;

  // A load in EX whose destination is read by the instruction in ID. Register
  // 0 is hardwired zero, so a load "into" r0 can never create a dependency.
  always_comb begin
    loadUse = i_IdEx_MemRead && (i_IdEx_Rt != '0) &&
              ((i_IdEx_Rt == i_IfId_Rs) || (i_IdEx_Rt == i_IfId_Rt));
  end

  // Forwarding is independent of FSM state. The EX/MEM result is younger than
  // the MEM/WB result, so it is checked first and wins when both match.
  always_comb begin
    fwdA = 2'b00;
    if (i_IdEx_Rs != '0) begin
      if (i_ExMem_RegWrite && (i_ExMem_Rd == i_IdEx_Rs)) begin
        fwdA = 2'b10;
      end else if (i_MemWb_RegWrite && (i_MemWb_Rd == i_IdEx_Rs)) begin
        fwdA = 2'b01;
      end
    end
  end

  always_comb begin
    fwdB = 2'b00;
    if (i_IdEx_Rt != '0) begin
      if (i_ExMem_RegWrite && (i_ExMem_Rd == i_IdEx_Rt)) begin
        fwdB = 2'b10;
      end else if (i_MemWb_RegWrite && (i_MemWb_Rd == i_IdEx_Rt)) begin
        fwdB = 2'b01;
      end
    end
  end

  // Next-state and control decode. The default branch of the case handles
  // RUN and also any unknown encoding, so a corrupted state behaves as RUN.
  // In FLUSH both the branch and load-use checks are dropped: MEM holds a
  // bubble and ID holds a squashed instruction.
  always_comb begin
    state_d    = RUN;
    takeStall  = 1'b0;
    takeFlush  = 1'b0;
    pcWrite    = 1'b1;
    ifIdWrite  = 1'b1;
    flushIfId  = 1'b0;
    flushIdEx  = 1'b0;
    flushExMem = 1'b0;
    case (state_q)
      FLUSH: begin
        state_d = RUN;
      end
      STALL: begin
        if (i_Branch_Taken) begin
          takeFlush = 1'b1;
        end
      end
      default: begin
        if (i_Branch_Taken) begin
          takeFlush = 1'b1;
        end else if (loadUse) begin
          takeStall = 1'b1;
        end
      end
    endcase

    if (takeFlush) begin
      state_d    = FLUSH;
      flushIfId  = 1'b1;
      flushIdEx  = 1'b1;
      flushExMem = 1'b1;
    end else if (takeStall) begin
      state_d   = STALL;
      pcWrite   = 1'b0;
      ifIdWrite = 1'b0;
      flushIdEx = 1'b1;
    end
  end

  // Counters stick at all-ones instead of wrapping.
  always_comb begin
    stallCnt_d = stallCnt_q;
    flushCnt_d = flushCnt_q;
    if (takeStall && (stallCnt_q != '1)) begin
      stallCnt_d = stallCnt_q + CNT_ONE;
    end
    if (takeFlush && (flushCnt_q != '1)) begin
      flushCnt_d = flushCnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      stallCnt_q <= stallCnt_d;
      flushCnt_q <= flushCnt_d;
    end
  end

  // Reset is applied straight to the outputs so the pipeline is frozen and
  // flushed the moment reset rises, not at the next clock edge.
  always_comb begin
    o_Pc_Write    = pcWrite & ~reset;
    o_IfId_Write  = ifIdWrite & ~reset;
    o_Flush_IfId  = flushIfId | reset;
    o_Flush_IdEx  = flushIdEx | reset;
    o_Flush_ExMem = flushExMem | reset;
    o_Fwd_A       = reset ? 2'b00 : fwdA;
    o_Fwd_B       = reset ? 2'b00 : fwdB;
    o_Stall_Count = stallCnt_q;
    o_Flush_Count = flushCnt_q;
  end

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit
// Directed bench for hazard_unit. A second instance with 4-bit counters
// shares all inputs so counter saturation can be reached in a few cycles.
// A behavioural model tracks "previous cycle stalled / flushed" and event
// totals; a negedge process compares every output against it, and the
// directed sequence adds hand-computed literal checks.

module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] ifIdRs = '0, ifIdRt = '0, idExRs = '0, idExRt = '0;
  logic       idExMemRead = 1'b0;
  logic [2:0] exMemRd = '0, memWbRd = '0;
  logic       exMemRegWrite = 1'b0, memWbRegWrite = 1'b0;
  logic       branchTaken = 1'b0;

  logic        pcWrite, ifIdWrite, flushIfId, flushIdEx, flushExMem;
  logic [1:0]  fwdA, fwdB;
  logic [15:0] stallCount, flushCount;

  logic        sPcWrite, sIfIdWrite, sFlushIfId, sFlushIdEx, sFlushExMem;
  logic [1:0]  sFwdA, sFwdB;
  logic [3:0]  sStallCount, sFlushCount;

  int testCount = 0;
  int failCount = 0;

  // Model state
  bit afterStall = 1'b0;
  bit afterFlush = 1'b0;
  int mStall = 0, mFlush = 0, mStallSmall = 0, mFlushSmall = 0;

  hazard_unit #(.REG_W(3), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .i_IfId_Rs(ifIdRs), .i_IfId_Rt(ifIdRt),
    .i_IdEx_Rs(idExRs), .i_IdEx_Rt(idExRt), .i_IdEx_MemRead(idExMemRead),
    .i_ExMem_Rd(exMemRd), .i_ExMem_RegWrite(exMemRegWrite),
    .i_MemWb_Rd(memWbRd), .i_MemWb_RegWrite(memWbRegWrite),
    .i_Branch_Taken(branchTaken),
    .o_Pc_Write(pcWrite), .o_IfId_Write(ifIdWrite),
    .o_Flush_IfId(flushIfId), .o_Flush_IdEx(flushIdEx), .o_Flush_ExMem(flushExMem),
    .o_Fwd_A(fwdA), .o_Fwd_B(fwdB),
    .o_Stall_Count(stallCount), .o_Flush_Count(flushCount)
  );

  hazard_unit #(.REG_W(3), .CNT_W(4)) dutSmall (
    .clk(clk), .reset(reset),
    .i_IfId_Rs(ifIdRs), .i_IfId_Rt(ifIdRt),
    .i_IdEx_Rs(idExRs), .i_IdEx_Rt(idExRt), .i_IdEx_MemRead(idExMemRead),
    .i_ExMem_Rd(exMemRd), .i_ExMem_RegWrite(exMemRegWrite),
    .i_MemWb_Rd(memWbRd), .i_MemWb_RegWrite(memWbRegWrite),
    .i_Branch_Taken(branchTaken),
    .o_Pc_Write(sPcWrite), .o_IfId_Write(sIfIdWrite),
    .o_Flush_IfId(sFlushIfId), .o_Flush_IdEx(sFlushIdEx), .o_Flush_ExMem(sFlushExMem),
    .o_Fwd_A(sFwdA), .o_Fwd_B(sFwdB),
    .o_Stall_Count(sStallCount), .o_Flush_Count(sFlushCount)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // What the pipeline should do this cycle: a taken branch is acted on unless
  // the previous cycle already flushed; a load-use stall only happens if the
  // previous cycle neither stalled nor flushed and no branch is acted on.
  function automatic void modelDecide(output bit doFlush, output bit doStall);
    bit lu;
    lu = idExMemRead && (idExRt != 3'd0) && ((idExRt == ifIdRs) || (idExRt == ifIdRt));
    doFlush = branchTaken && !afterFlush;
    doStall = !doFlush && lu && !afterStall && !afterFlush;
  endfunction

  function automatic logic [1:0] modelFwd(input logic [2:0] src);
    if (src == 3'd0) return 2'b00;
    if (exMemRegWrite && exMemRd == src) return 2'b10;
    if (memWbRegWrite && memWbRd == src) return 2'b01;
    return 2'b00;
  endfunction

  always @(posedge clk or posedge reset) begin
    bit f, s;
    if (reset) begin
      afterStall = 1'b0;
      afterFlush = 1'b0;
      mStall = 0; mFlush = 0; mStallSmall = 0; mFlushSmall = 0;
    end else begin
      modelDecide(f, s);
      afterFlush = f;
      afterStall = s;
      if (f) begin
        mFlush = (mFlush < 65535) ? mFlush + 1 : 65535;
        mFlushSmall = (mFlushSmall < 15) ? mFlushSmall + 1 : 15;
      end
      if (s) begin
        mStall = (mStall < 65535) ? mStall + 1 : 65535;
        mStallSmall = (mStallSmall < 15) ? mStallSmall + 1 : 15;
      end
    end
  end

  // Compare every output against the model once per cycle, mid-cycle.
  always @(negedge clk) begin
    bit f, s;
    logic expPc, expFIfId, expFIdEx, expFExMem;
    logic [1:0] expA, expB;
    if (reset) begin
      expPc = 1'b0; expFIfId = 1'b1; expFIdEx = 1'b1; expFExMem = 1'b1;
      expA = 2'b00; expB = 2'b00;
    end else begin
      modelDecide(f, s);
      expPc = !s; expFIfId = f; expFIdEx = f || s; expFExMem = f;
      expA = modelFwd(idExRs); expB = modelFwd(idExRt);
    end
    checkOutput("pcWrite", 32'(pcWrite), 32'(expPc));
    checkOutput("ifIdWrite", 32'(ifIdWrite), 32'(expPc));
    checkOutput("flushIfId", 32'(flushIfId), 32'(expFIfId));
    checkOutput("flushIdEx", 32'(flushIdEx), 32'(expFIdEx));
    checkOutput("flushExMem", 32'(flushExMem), 32'(expFExMem));
    checkOutput("fwdA", 32'(fwdA), 32'(expA));
    checkOutput("fwdB", 32'(fwdB), 32'(expB));
    checkOutput("stallCount", 32'(stallCount), 32'(mStall));
    checkOutput("flushCount", 32'(flushCount), 32'(mFlush));
    checkOutput("smallPcWrite", 32'(sPcWrite), 32'(expPc));
    checkOutput("smallStallCount", 32'(sStallCount), 32'(mStallSmall));
    checkOutput("smallFlushCount", 32'(sFlushCount), 32'(mFlushSmall));
  end

  task automatic applyStimulus(input logic [2:0] iRs, input logic [2:0] iRt,
                               input logic [2:0] eRs, input logic [2:0] eRt,
                               input logic memRd,
                               input logic [2:0] emRd, input logic emRW,
                               input logic [2:0] mwRd, input logic mwRW,
                               input logic br);
    @(posedge clk);
    #1;
    ifIdRs = iRs; ifIdRt = iRt; idExRs = eRs; idExRt = eRt;
    idExMemRead = memRd;
    exMemRd = emRd; exMemRegWrite = emRW;
    memWbRd = mwRd; memWbRegWrite = mwRW;
    branchTaken = br;
  endtask

  task automatic holdCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    // Reset with a forwarding match present: selects must still read 00
    exMemRd = 3'd3; exMemRegWrite = 1'b1; idExRs = 3'd3;
    settle();
    checkOutput("rst pcWrite", 32'(pcWrite), 32'd0);
    checkOutput("rst ifIdWrite", 32'(ifIdWrite), 32'd0);
    checkOutput("rst flushIfId", 32'(flushIfId), 32'd1);
    checkOutput("rst flushIdEx", 32'(flushIdEx), 32'd1);
    checkOutput("rst flushExMem", 32'(flushExMem), 32'd1);
    checkOutput("rst fwdA", 32'(fwdA), 32'd0);
    checkOutput("rst stallCount", 32'(stallCount), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Forwarding priority
    applyStimulus(3'd0, 3'd0, 3'd3, 3'd5, 1'b0, 3'd3, 1'b1, 3'd3, 1'b1, 1'b0);
    settle();
    checkOutput("fwd prio A", 32'(fwdA), 32'd2);
    checkOutput("fwd prio B", 32'(fwdB), 32'd0);
    applyStimulus(3'd0, 3'd0, 3'd3, 3'd5, 1'b0, 3'd3, 1'b0, 3'd3, 1'b1, 1'b0);
    settle();
    checkOutput("fwd memwb A", 32'(fwdA), 32'd1);
    applyStimulus(3'd0, 3'd0, 3'd3, 3'd5, 1'b0, 3'd7, 1'b1, 3'd5, 1'b1, 1'b0);
    settle();
    checkOutput("fwd none A", 32'(fwdA), 32'd0);
    checkOutput("fwd memwb B", 32'(fwdB), 32'd1);

    // Register zero
    applyStimulus(3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd0, 1'b1, 1'b0);
    settle();
    checkOutput("r0 fwdA", 32'(fwdA), 32'd0);
    checkOutput("r0 fwdB", 32'(fwdB), 32'd0);
    applyStimulus(3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    settle();
    checkOutput("r0 no stall", 32'(pcWrite), 32'd1);

    // Load-use held for four cycles: stall, stall-state, stall, stall-state
    applyStimulus(3'd1, 3'd2, 3'd0, 3'd2, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    settle();
    checkOutput("lu pcWrite", 32'(pcWrite), 32'd0);
    checkOutput("lu ifIdWrite", 32'(ifIdWrite), 32'd0);
    checkOutput("lu flushIdEx", 32'(flushIdEx), 32'd1);
    checkOutput("lu flushIfId", 32'(flushIfId), 32'd0);
    checkOutput("lu count before", 32'(stallCount), 32'd0);
    holdCycle(); settle();
    checkOutput("lu2 pcWrite", 32'(pcWrite), 32'd1);
    checkOutput("lu2 count", 32'(stallCount), 32'd1);
    holdCycle(); settle();
    checkOutput("lu3 pcWrite", 32'(pcWrite), 32'd0);
    checkOutput("lu3 count", 32'(stallCount), 32'd1);
    holdCycle(); settle();
    checkOutput("lu4 count", 32'(stallCount), 32'd2);
    applyStimulus(3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);

    // Branch together with load-use: branch wins, then ignored in FLUSH
    applyStimulus(3'd4, 3'd0, 3'd0, 3'd4, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1);
    settle();
    checkOutput("br flushIfId", 32'(flushIfId), 32'd1);
    checkOutput("br flushIdEx", 32'(flushIdEx), 32'd1);
    checkOutput("br flushExMem", 32'(flushExMem), 32'd1);
    checkOutput("br pcWrite", 32'(pcWrite), 32'd1);
    holdCycle(); settle();
    checkOutput("br2 flushExMem", 32'(flushExMem), 32'd0);
    checkOutput("br2 pcWrite", 32'(pcWrite), 32'd1);
    checkOutput("br2 flushCount", 32'(flushCount), 32'd1);
    checkOutput("br2 stallCount", 32'(stallCount), 32'd2);
    applyStimulus(3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);

    // Branch arriving while in STALL
    applyStimulus(3'd1, 3'd2, 3'd0, 3'd2, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    applyStimulus(3'd1, 3'd2, 3'd0, 3'd2, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1);
    settle();
    checkOutput("stbr flushExMem", 32'(flushExMem), 32'd1);
    checkOutput("stbr stallCount", 32'(stallCount), 32'd3);
    holdCycle(); settle();
    checkOutput("stbr flushCount", 32'(flushCount), 32'd2);
    checkOutput("stbr2 flushExMem", 32'(flushExMem), 32'd0);
    applyStimulus(3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);

    // Asynchronous reset while in STALL
    applyStimulus(3'd1, 3'd2, 3'd0, 3'd2, 1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 1'b0);
    holdCycle();
    #2 reset = 1'b1;
    #1;
    checkOutput("ar pcWrite", 32'(pcWrite), 32'd0);
    checkOutput("ar flushIfId", 32'(flushIfId), 32'd1);
    checkOutput("ar flushExMem", 32'(flushExMem), 32'd1);
    checkOutput("ar fwdB", 32'(fwdB), 32'd0);
    checkOutput("ar stallCount", 32'(stallCount), 32'd0);
    checkOutput("ar flushCount", 32'(flushCount), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    settle();
    checkOutput("ar restall pcWrite", 32'(pcWrite), 32'd0);
    checkOutput("ar restall flushIdEx", 32'(flushIdEx), 32'd1);

    // Saturation of the 4-bit counters
    for (int i = 0; i < 40; i++) holdCycle();
    settle();
    checkOutput("sat stall", 32'(sStallCount), 32'd15);
    holdCycle(); holdCycle(); settle();
    checkOutput("sat stall hold", 32'(sStallCount), 32'd15);
    applyStimulus(3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) holdCycle();
    settle();
    checkOutput("sat flush", 32'(sFlushCount), 32'd15);
    applyStimulus(3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    holdCycle(); holdCycle(); settle();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Control-side counterpart of the ID/EX pipeline register in the 16-bit, 8-register pipelined MIPS.
- Consumes the register fields and control bits the decode, ID/EX, EX/MEM and MEM/WB stages publish.
- Drives stall, flush/bubble and forwarding controls back into those registers and the EX operand muxes.
- Owns a small FSM that enforces single-cycle load-use bubbles and branch flushes, plus saturating event counters.

Parameters:
- REG_W, 3, register-index width.
- CNT_W, 16, width of the stall and flush event counters.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- i_IfId_Rs  in  REG_W  rs field of the instruction in ID.
- i_IfId_Rt  in  REG_W  rt field of the instruction in ID.
- i_IdEx_Rs  in  REG_W  rs of the instruction in EX.
- i_IdEx_Rt  in  REG_W  rt of the instruction in EX.
- i_IdEx_MemRead  in  1  instruction in EX is a load.
- i_ExMem_Rd  in  REG_W  destination register in MEM.
- i_ExMem_RegWrite  in  1  MEM instruction writes the register file.
- i_MemWb_Rd  in  REG_W  destination register in WB.
- i_MemWb_RegWrite  in  1  WB instruction writes the register file.
- i_Branch_Taken  in  1  branch resolved taken in MEM.
- o_Pc_Write  out  1  PC update enable.
- o_IfId_Write  out  1  IF/ID load enable.
- o_Flush_IfId  out  1  zero the IF/ID contents.
- o_Flush_IdEx  out  1  zero the ID/EX control bits (bubble).
- o_Flush_ExMem  out  1  zero the EX/MEM control bits.
- o_Fwd_A  out  2  EX operand A select: 00 register file, 10 EX/MEM result, 01 MEM/WB result.
- o_Fwd_B  out  2  EX operand B select, same encoding as o_Fwd_A.
- o_Stall_Count  out  CNT_W  number of load-use stalls taken.
- o_Flush_Count  out  CNT_W  number of branch flushes taken.

Behaviour:
- Clock and reset: the clock is clk; reset is asynchronous and active-high.
- Timing: the state register and counters update on the rising edge of clk. Control outputs are combinational from the inputs and current state, and must be settled before the falling edge, where the pipeline registers sample.
- Register 0 is hardwired zero. Any index equal to 0 never causes a hazard and never causes forwarding.
- Forwarding, applied to A using i_IdEx_Rs and to B using i_IdEx_Rt, independent of FSM state:
  - If i_ExMem_RegWrite and i_ExMem_Rd equals the source, the select is 10.
  - Otherwise, if i_MemWb_RegWrite and i_MemWb_Rd equals the source, the select is 01.
  - Otherwise the select is 00.
  - EX/MEM wins when both match.
- Load-use detection (loaduse): i_IdEx_MemRead, i_IdEx_Rt != 0, and i_IdEx_Rt equals i_IfId_Rs or i_IfId_Rt.
- FSM states RUN, STALL, FLUSH; reset state is RUN.
- RUN state:
  - If i_Branch_Taken: assert all three flushes; o_Pc_Write=1 so the branch target loads; o_IfId_Write=1; next state FLUSH; o_Flush_Count increments. Branch takes priority over loaduse.
  - Else if loaduse: o_Pc_Write=0, o_IfId_Write=0, o_Flush_IdEx=1; next state STALL; o_Stall_Count increments.
  - Else: o_Pc_Write=1, o_IfId_Write=1, all flushes 0; stay in RUN.
- STALL state (exactly one cycle):
  - loaduse detection is suppressed.
  - i_Branch_Taken is honoured exactly as in RUN (flush, count, go to FLUSH).
  - Otherwise normal enables; return to RUN.
- FLUSH state (exactly one cycle):
  - i_Branch_Taken is ignored, because MEM holds a flushed bubble.
  - loaduse is ignored, because ID holds a flushed instruction.
  - Normal enables; next state RUN.
- Counters: saturate at all-ones; they never wrap.
- While reset is high:
  - o_Pc_Write=0, o_IfId_Write=0.
  - o_Flush_IfId, o_Flush_IdEx and o_Flush_ExMem all =1.
  - o_Fwd_A and o_Fwd_B =00.
  - Counters =0, state=RUN.
- Reset asserted mid-STALL or mid-FLUSH returns to RUN immediately. On deassertion, normal RUN decoding resumes the next cycle.
- No X propagation: unknown state encodings decode as RUN.

Test Plan:
- Forwarding priority: ExMem_Rd=3 with RegWrite=1, MemWb_Rd=3 with RegWrite=1, IdEx_Rs=3, IdEx_Rt=5 -> o_Fwd_A=10, o_Fwd_B=00. Then drop ExMem_RegWrite -> o_Fwd_A=01.
- Zero register: ExMem_Rd=0 with RegWrite=1, IdEx_Rs=0 -> o_Fwd_A=00. IdEx_MemRead=1 with IdEx_Rt=0 and IfId_Rs=0 -> no stall.
- Load-use: IdEx_MemRead=1, IdEx_Rt=2, IfId_Rt=2 -> for one cycle o_Pc_Write=0, o_IfId_Write=0, o_Flush_IdEx=1, and o_Stall_Count goes 0->1. Holding the inputs constant for another cycle -> no second stall (STALL state), then state returns to RUN.
- Branch over stall: loaduse and i_Branch_Taken asserted together -> all three flushes =1, o_Pc_Write=1, o_Flush_Count +1, o_Stall_Count unchanged. Branch held a second cycle -> ignored in FLUSH, count unchanged.
- Saturation: preload by issuing 65535 stalls -> o_Stall_Count=0xFFFF; one more stall -> stays 0xFFFF.
- Async reset mid-STALL: assert reset between edges -> outputs immediately take their reset values and counters =0. After release, a loaduse condition stalls again from RUN.
